// File: rtl/mic1_mem_responder.sv
// ----------------------------------------------------------------------------
// mic1_mem_responder
//
// Memory-side responder for the CPU's byte-serial memory port. A request is
// framed on the 8-bit inbound bus as four little-endian address bytes, which
// are followed by four little-endian data bytes for writes. The access goes to
// an internal 2**AW x 32-bit word RAM. Read data returns on the 8-bit outbound
// bus as four little-endian bytes under out_valid/out_ready flow control.
//
// Ports
//   clk        in   1  system clock; all state changes on posedge
//   rst_n      in   1  asynchronous active-low reset
//   in_byte    in   8  inbound byte (address bytes, then write-data bytes)
//   in_valid   in   1  in_byte valid this cycle
//   in_sof     in   1  first beat of a request (qualified by in_valid)
//   in_wr      in   1  request type, sampled with the in_sof beat (1 = write)
//   in_ready   out  1  responder accepts an inbound byte this cycle
//   out_byte   out  8  read-data byte (0 when out_valid is low)
//   out_valid  out  1  out_byte valid
//   out_ready  in   1  CPU accepts out_byte this cycle
//   busy       out  1  a request is in progress
//   err        out  1  one-cycle pulse: out-of-range address or framing error
// ----------------------------------------------------------------------------
module mic1_mem_responder #(
    parameter int AW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_wr,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RACC  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    logic [2:0]  r_state;
    logic [1:0]  r_cnt;     // beat index within the current 4-byte phase
    logic [23:0] r_addr;    // address bytes 0..2; byte 3 arrives with the last beat
    logic [23:0] r_wdata;   // write-data bytes 0..2; byte 3 arrives with the last beat
    logic        r_wr;
    logic        r_oor;     // latched out-of-range flag for the current request
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [0:(2**AW)-1];

    logic        w_accept;
    logic [31:0] w_addr_full;
    logic        w_addr_oor;
    logic        w_mem_we;
    logic [31:0] w_mem_wdata;
    logic [7:0]  w_rd_byte;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
    assign out_valid = (r_state == S_RDATA);
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

    assign w_accept = in_valid && in_ready;

    // The full address only exists while its last byte is on the bus.
    assign w_addr_full = {in_byte, r_addr};
    assign w_addr_oor  = |w_addr_full[31:AW];

    // A start-of-frame beat during WDATA aborts the write, so it never commits.
    assign w_mem_we    = w_accept && !in_sof && (r_state == S_WDATA) && (r_cnt == 2'd3) && !r_oor;
    assign w_mem_wdata = {in_byte, r_wdata};

    // NOTE: every variable driven in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_cnt)
            2'd0:    w_rd_byte = r_rdata[7:0];
            2'd1:    w_rd_byte = r_rdata[15:8];
            2'd2:    w_rd_byte = r_rdata[23:16];
            default: w_rd_byte = r_rdata[31:24];
        endcase
    end

    assign out_byte = out_valid ? w_rd_byte : 8'h00;

    // NOTE: the RAM array and its read register have no reset; clearing a
    // memory on reset is not wanted, and out_byte is masked until RDATA.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr[AW-1:0]] <= w_mem_wdata;
        end
        if (r_state == S_RACC) begin
            r_rdata <= r_oor ? 32'h0 : r_mem[r_addr[AW-1:0]];
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= 24'h0;
            r_wdata <= 24'h0;
            r_wr    <= 1'b0;
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            r_addr[7:0] <= in_byte;
                            r_wr        <= in_wr;
                            r_cnt       <= 2'd1;
                            r_state     <= S_ADDR;
                        end else begin
                            // Stray beat outside a frame: drop it and flag it.
                            r_err <= 1'b1;
                        end
                    end
                end

                S_ADDR, S_WDATA: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            // Restart: the aborting beat is byte 0 of a new request.
                            r_err       <= 1'b1;
                            r_addr[7:0] <= in_byte;
                            r_wr        <= in_wr;
                            r_cnt       <= 2'd1;
                            r_state     <= S_ADDR;
                        end else begin
                            // The counter wraps 3 -> 0, ready for the next phase.
                            r_cnt <= r_cnt + 2'd1;
                            if (r_state == S_ADDR) begin
                                case (r_cnt)
                                    2'd1:    r_addr[15:8]  <= in_byte;
                                    2'd2:    r_addr[23:16] <= in_byte;
                                    default: ;
                                endcase
                                if (r_cnt == 2'd3) begin
                                    r_oor   <= w_addr_oor;
                                    r_state <= r_wr ? S_WDATA : S_RACC;
                                    if (!r_wr && w_addr_oor) begin
                                        r_err <= 1'b1;
                                    end
                                end
                            end else begin
                                case (r_cnt)
                                    2'd0:    r_wdata[7:0]   <= in_byte;
                                    2'd1:    r_wdata[15:8]  <= in_byte;
                                    2'd2:    r_wdata[23:16] <= in_byte;
                                    default: ;
                                endcase
                                if (r_cnt == 2'd3) begin
                                    r_state <= S_IDLE;
                                    if (r_oor) begin
                                        r_err <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end

                S_RACC: begin
                    r_cnt   <= 2'd0;
                    r_state <= S_RDATA;
                end

                S_RDATA: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic1_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mic1_mem_responder
//
// Self-checking bench for mic1_mem_responder (AW = 8). Directed scenarios and a
// randomized phase are checked against a word-array model of the RAM. Inputs
// change and outputs are sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_mic1_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_sof;
    logic       in_wr;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: RAM words plus a record of which words hold known data.
    logic [31:0] m_mem   [0:255];
    bit          m_known [0:255];

    mic1_mem_responder #(.AW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_wr     (in_wr),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_wr    = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic beat(input logic [7:0] b, input logic sof, input logic wr);
        check("beat_in_ready", in_ready, 1);
        in_byte  = b;
        in_valid = 1'b1;
        in_sof   = sof;
        in_wr    = wr;
        step();
    endtask

    task automatic send_addr(input logic [31:0] addr, input logic wr);
        for (int i = 0; i < 4; i++) begin
            beat(addr[8*i +: 8], (i == 0), wr);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] addr);
        return (addr[31:8] != 24'h0);
    endfunction

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        send_addr(addr, 1'b1);
        check("wr_addr_no_err", err, 0);
        for (int i = 0; i < 4; i++) begin
            beat(data[8*i +: 8], 1'b0, 1'b0);
        end
        idle_in();
        check("wr_err", err, is_oor(addr));
        check("wr_busy", busy, 0);
        if (!is_oor(addr)) begin
            m_mem[addr[7:0]]   = data;
            m_known[addr[7:0]] = 1'b1;
        end
        step();
        check("wr_err_single", err, 0);
    endtask

    // Called right after the edge that accepted the last address beat.
    task automatic finish_read(input logic [31:0] addr, input logic [15:0] pat,
                               input int pat_len, input bit use_pat, output int cycles);
        logic [31:0] exp;
        int          k;
        int          n;
        logic        rdy;
        exp = is_oor(addr) ? 32'h0 : m_mem[addr[7:0]];
        idle_in();
        check("rd_lat_racc_valid", out_valid, 0);
        check("rd_racc_in_ready", in_ready, 0);
        check("rd_err", err, is_oor(addr));
        step();
        check("rd_lat_first_valid", out_valid, 1);
        check("rd_err_single", err, 0);
        k = 0;
        n = 0;
        while (k < 4 && n < 64) begin
            if (use_pat) rdy = (n < pat_len) ? pat[n] : 1'b1;
            else         rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            check("rd_valid", out_valid, 1);
            check("rd_byte", out_byte, exp[8*k +: 8]);
            check("rd_in_ready", in_ready, 0);
            step();
            if (rdy) k++;
            n++;
        end
        out_ready = 1'b0;
        if (k < 4) check("rd_timeout", k, 4);
        check("rd_done_valid", out_valid, 0);
        check("rd_done_busy", busy, 0);
        cycles = n;
    endtask

    task automatic read_word(input logic [31:0] addr, input logic [15:0] pat,
                             input int pat_len, input bit use_pat);
        int cyc;
        send_addr(addr, 1'b0);
        finish_read(addr, pat, pat_len, use_pat, cyc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_byte"},  out_byte,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_err"},       err,       0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        int          kind;

        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = 32'h0;
            m_known[i] = 1'b0;
        end
        idle_in();
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check_reset_state("rst_async");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check_reset_state("rst_release");

        // Basic write then read, little-endian on both buses.
        write_word(32'h0000_0000, 32'h1122_3344);
        write_word(32'h0000_0005, 32'hDEAD_BEEF);
        check("model_deadbeef", m_mem[5], 32'hDEAD_BEEF);
        read_word(32'h0000_0005, 16'hFFFF, 16, 1'b1);

        // Stalled read with out_ready pattern 1,0,0,1,1,0,1.
        send_addr(32'h0000_0005, 1'b0);
        finish_read(32'h0000_0005, 16'h0059, 7, 1'b1, cyc);
        check("rd_pattern_cycles", cyc, 7);

        // Out-of-range write and read.
        write_word(32'h0000_0100, 32'hA5A5_5A5A);
        read_word(32'h0000_0000, 16'hFFFF, 16, 1'b1);
        read_word(32'h0000_0100, 16'hFFFF, 16, 1'b1);

        // Abort at address beat 2 of a write; the aborting beat starts a read of 0x5.
        beat(8'h40, 1'b1, 1'b1);
        beat(8'h00, 1'b0, 1'b0);
        check("abort_addr_no_err", err, 0);
        beat(8'h05, 1'b1, 1'b0);
        check("abort_addr_err", err, 1);
        beat(8'h00, 1'b0, 1'b0);
        check("abort_addr_err_single", err, 0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        finish_read(32'h0000_0005, 16'hFFFF, 16, 1'b1, cyc);

        // Abort on the last data beat of a write: the old word must survive.
        write_word(32'h0000_000A, 32'hCAFE_F00D);
        send_addr(32'h0000_000A, 1'b1);
        beat(8'h11, 1'b0, 1'b0);
        beat(8'h22, 1'b0, 1'b0);
        beat(8'h33, 1'b0, 1'b0);
        beat(8'h0A, 1'b1, 1'b0);
        check("abort_wdata_err", err, 1);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        finish_read(32'h0000_000A, 16'hFFFF, 16, 1'b1, cyc);

        // Stray beat in IDLE.
        beat(8'hA5, 1'b0, 1'b1);
        idle_in();
        check("stray_err", err, 1);
        check("stray_busy", busy, 0);
        check("stray_in_ready", in_ready, 1);
        step();
        check("stray_err_single", err, 0);
        check("stray_still_idle", busy, 0);
        read_word(32'h0000_0005, 16'hFFFF, 16, 1'b1);

        // Reset while byte 1 of a read is on the bus.
        send_addr(32'h0000_0005, 1'b0);
        idle_in();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("rstmid_byte1", out_byte, 8'hBE);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("rstmid");
        #2 rst_n = 1'b1;
        step();
        read_word(32'h0000_0005, 16'hFFFF, 16, 1'b1);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3) begin
                a = 32'($urandom_range(0, 255));
                d = $urandom;
                write_word(a, d);
            end else if (kind == 4) begin
                a = $urandom;
                if (a[31:8] == 24'h0) a[8] = 1'b1;
                write_word(a, $urandom);
            end else if (kind <= 8) begin
                a = 32'h5;
                for (int t = 0; t < 64; t++) begin
                    logic [31:0] c;
                    c = 32'($urandom_range(0, 255));
                    if (m_known[c[7:0]]) begin
                        a = c;
                        break;
                    end
                end
                read_word(a, 16'h0, 0, 1'b0);
            end else begin
                a = $urandom;
                if (a[31:8] == 24'h0) a[31] = 1'b1;
                read_word(a, 16'h0, 0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
